rsp_s2_prep_axi4_m_rd: RTL and testbench

AXI4 read master that fetches a frame of DATA_NUM beats from memory in fixed-length INCR bursts, starting at INIT_ADDR. It is the read-back counterpart of the stage-2 prep write master. Read data is streamed into a downstream FIFO. A burst is issued only when that FIFO has room for the whole burst, so the block never back-pressures the R channel indefinitely.

---
 rtl/rsp_s2_prep_pkg.sv | 22 ++
 rtl/axi_v4_rd_if.sv | 33 +++
 rtl/rsp_s2_prep_axi4_m_rd.sv | 169 ++++++++++++++++
 tb/tb_rsp_s2_prep_axi4_m_rd.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsp_s2_prep_pkg.sv
// Shared types and AXI4 read-channel constants for the stage-2 prep read master.
package rsp_s2_prep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ROOM = 3'd1,
    ST_AR        = 3'd2,
    ST_RDATA     = 3'd3,
    ST_DONE      = 3'd4
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [2:0] AXI_SIZE_16B   = 3'd4;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'd0;
  localparam logic [3:0] RD_ID          = 4'd1;

  // AXI size encoding for a bus of the given byte width
  function automatic logic [2:0] axi_size_f(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_v4_rd_if.sv
// AXI4 read address / read data channel bundle.
interface axi_v4_rd_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arlock;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/rsp_s2_prep_axi4_m_rd.sv
// AXI4 read master: fetches one frame as fixed-length INCR bursts into a downstream
// FIFO, requesting a burst only when the FIFO can absorb all of it.
module rsp_s2_prep_axi4_m_rd
  import rsp_s2_prep_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_NUM   = 1024,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned INIT_ADDR  = 32'd0,
  parameter int unsigned ADD_ADDR   = 32'd128,
  parameter int unsigned END_ADDR   = 32'd16384,
  parameter int unsigned FIFO_CNT   = 7,
  parameter int unsigned FIFO_DEPTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [FIFO_CNT:0]     fifo_word_counter,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_busy,
  output logic                  o_finish,
  output logic                  o_err,
  axi_v4_rd_if.master           m_axi_rd
);

  localparam int unsigned BURST_NUM = DATA_NUM / BURST_LEN;
  localparam int unsigned BURST_W   = $clog2(BURST_NUM) + 1;
  localparam int unsigned BEAT_W    = $clog2(BURST_LEN) + 1;
  localparam int unsigned FCNT_W    = FIFO_CNT + 1;

  localparam logic [BURST_W-1:0]    LAST_BURST_C = BURST_W'(BURST_NUM - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT_C  = BEAT_W'(BURST_LEN - 1);
  localparam logic [FCNT_W-1:0]     ROOM_C       = FCNT_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] INIT_ADDR_C  = ADDR_WIDTH'(INIT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADD_ADDR_C   = ADDR_WIDTH'(ADD_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_ADDR_C   = ADDR_WIDTH'(END_ADDR);
  localparam logic [2:0]            ARSIZE_C     = axi_size_f(DATA_WIDTH / 8);

  rd_state_e             state_r;
  logic                  arvalid_r;
  logic                  rready_r;
  logic                  busy_r;
  logic                  finish_r;
  logic                  err_r;
  logic [ADDR_WIDTH-1:0] araddr_r;
  logic [BEAT_W-1:0]     beat_cnt_r;
  logic [BURST_W-1:0]    burst_cnt_r;

  logic [ADDR_WIDTH-1:0] addr_inc_s;
  logic [ADDR_WIDTH-1:0] addr_next_s;
  logic                  room_s;
  logic                  beat_fire_s;
  logic                  last_beat_s;
  logic                  beat_err_s;

  assign room_s      = (fifo_word_counter <= ROOM_C);
  assign beat_fire_s = m_axi_rd.rvalid & rready_r;
  assign last_beat_s = (beat_cnt_r == LAST_BEAT_C);

  // Beat counting is authoritative; rlast, rresp and rid are only checked against it
  assign beat_err_s = beat_fire_s &
                      ((m_axi_rd.rlast != last_beat_s) |
                       (m_axi_rd.rresp != AXI_RESP_OKAY) |
                       (m_axi_rd.rid != RD_ID));

  // Next burst address, wrapping back to the frame base at the exclusive limit
  always_comb begin
    addr_inc_s = araddr_r + ADD_ADDR_C;
    if (addr_inc_s >= END_ADDR_C) begin
      addr_next_s = INIT_ADDR_C;
    end else begin
      addr_next_s = addr_inc_s;
    end
  end

  // Frame sequencing: room check, address phase, beat collection, completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      busy_r      <= 1'b0;
      finish_r    <= 1'b0;
      err_r       <= 1'b0;
      araddr_r    <= INIT_ADDR_C;
      beat_cnt_r  <= '0;
      burst_cnt_r <= '0;
    end else begin
      finish_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            state_r     <= ST_WAIT_ROOM;
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            araddr_r    <= INIT_ADDR_C;
            beat_cnt_r  <= '0;
            burst_cnt_r <= '0;
          end
        end
        ST_WAIT_ROOM: begin
          if (room_s) begin
            state_r   <= ST_AR;
            arvalid_r <= 1'b1;
          end
        end
        ST_AR: begin
          if (m_axi_rd.arready) begin
            state_r   <= ST_RDATA;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
          end
        end
        ST_RDATA: begin
          if (beat_fire_s) begin
            if (beat_err_s) begin
              err_r <= 1'b1;
            end
            if (last_beat_s) begin
              beat_cnt_r  <= '0;
              burst_cnt_r <= burst_cnt_r + BURST_W'(1);
              araddr_r    <= addr_next_s;
              rready_r    <= 1'b0;
              if (burst_cnt_r == LAST_BURST_C) begin
                state_r  <= ST_DONE;
                finish_r <= 1'b1;
                busy_r   <= 1'b0;
              end else begin
                state_r <= ST_WAIT_ROOM;
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign m_axi_rd.arid    = RD_ID;
  assign m_axi_rd.araddr  = araddr_r;
  assign m_axi_rd.arlen   = 8'(BURST_LEN - 1);
  assign m_axi_rd.arsize  = ARSIZE_C;
  assign m_axi_rd.arburst = AXI_BURST_INCR;
  assign m_axi_rd.arcache = 4'd0;
  assign m_axi_rd.arprot  = 3'd0;
  assign m_axi_rd.arlock  = 1'b0;
  assign m_axi_rd.arvalid = arvalid_r;
  assign m_axi_rd.rready  = rready_r;

  // Read data goes straight to the FIFO write port with no added latency
  assign o_data       = m_axi_rd.rdata;
  assign o_data_valid = beat_fire_s;
  assign o_busy       = busy_r;
  assign o_finish     = finish_r;
  assign o_err        = err_r;

endmodule

// File: tb/tb_rsp_s2_prep_axi4_m_rd.sv
// Scoreboard bench for rsp_s2_prep_axi4_m_rd: an AXI slave model feeds bursts while a
// monitor pops expected addresses and beats whenever the DUT presents them.
module tb_rsp_s2_prep_axi4_m_rd;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [7:0]   fifo_word_counter;
  logic [127:0] o_data;
  logic         o_data_valid;
  logic         o_busy;
  logic         o_finish;
  logic         o_err;

  axi_v4_rd_if #(.DATA_WIDTH(128), .ADDR_WIDTH(32), .ID_WIDTH(4)) axi ();

  rsp_s2_prep_axi4_m_rd #(
    .DATA_WIDTH(128), .ADDR_WIDTH(32), .DATA_NUM(64), .BURST_LEN(8),
    .INIT_ADDR(32'd0), .ADD_ADDR(32'd128), .END_ADDR(32'd512),
    .FIFO_CNT(7), .FIFO_DEPTH(128)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .fifo_word_counter(fifo_word_counter),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_busy(o_busy),
    .o_finish(o_finish), .o_err(o_err), .m_axi_rd(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int beats_seen = 0;

  // slave model knobs
  int ar_stall       = 0;
  bit r_toggle       = 1'b0;
  bit inj_armed      = 1'b0;
  int inj_rlast_beat = -1;
  int inj_resp_beat  = -1;

  logic [31:0]  exp_addr_q[$];
  logic [127:0] exp_data_q[$];

  // 8 bursts of 128 bytes with the 512-byte wrap point
  logic [31:0] exp_addrs [8] = '{32'd0, 32'd128, 32'd256, 32'd384,
                                 32'd0, 32'd128, 32'd256, 32'd384};

  function automatic logic [127:0] mk_data(input logic [31:0] a, input int b);
    logic [31:0] bb;
    bb = 32'(b);
    return {32'hC0DE_0000 ^ bb, a, ~a, bb * 32'h0101_0101};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %b required %b", nm, act, exp);
    end
  endtask

  // AXI slave model: values driven just after each rising edge
  initial begin : slave
    bit          ar_fire, r_fire, rst_seen, tog;
    int          sl_beat, ar_wait;
    bit          sl_active;
    logic [31:0] ar_a, sl_addr;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = 4'd0; axi.rdata = '0;
    axi.rresp = 2'b00; axi.rlast = 1'b0;
    tog = 1'b0; sl_beat = 0; ar_wait = 0; sl_active = 1'b0; sl_addr = 32'd0;
    forever begin
      @(negedge clk);
      ar_fire  = axi.arvalid && axi.arready;
      r_fire   = axi.rvalid && axi.rready;
      rst_seen = rst;
      ar_a     = axi.araddr;
      @(posedge clk); #1;
      if (rst_seen) begin
        sl_active = 1'b0;
        ar_wait   = 0;
      end else begin
        if (r_fire) begin
          if (sl_beat == 7) inj_armed = 1'b0;
          sl_beat++;
          if (sl_beat == 8) sl_active = 1'b0;
        end
        if (ar_fire) begin
          sl_active = 1'b1; sl_beat = 0; sl_addr = ar_a; ar_wait = 0;
        end else if (axi.arvalid) begin
          ar_wait++;
        end
      end
      tog = !tog;
      axi.arready = (ar_wait >= ar_stall);
      axi.rvalid  = sl_active && (!r_toggle || tog);
      axi.rdata   = mk_data(sl_addr, sl_beat);
      axi.rid     = 4'd1;
      axi.rlast   = (sl_beat == 7) || (inj_armed && inj_rlast_beat == sl_beat);
      axi.rresp   = (inj_armed && inj_resp_beat == sl_beat) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: compares AR requests and FIFO writes against the scoreboard
  initial begin : monitor
    bit          prev_pend;
    logic [31:0] prev_addr;
    prev_pend = 1'b0; prev_addr = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) begin
          chk1("ar_hold_valid", axi.arvalid, 1'b1);
          chk("ar_hold_addr", 128'(axi.araddr), 128'(prev_addr));
        end
        if (axi.arvalid && axi.rready) chk1("ar_during_rdata", 1'b1, 1'b0);
        if (axi.arvalid && axi.arready) begin
          chk1("ar_expected", exp_addr_q.size() != 0, 1'b1);
          if (exp_addr_q.size() != 0) chk("araddr", 128'(axi.araddr), 128'(exp_addr_q.pop_front()));
          chk("ar_fields", 128'({axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arcache,
                                 axi.arprot, axi.arlock}),
              128'({4'd1, 8'd7, 3'd4, 2'd1, 4'd0, 3'd0, 1'b0}));
        end
        if (axi.rvalid && !axi.rready) chk1("dvalid_gated", o_data_valid, 1'b0);
        if (o_data_valid) begin
          beats_seen++;
          chk1("beat_expected", exp_data_q.size() != 0, 1'b1);
          if (exp_data_q.size() != 0) chk("o_data", o_data, exp_data_q.pop_front());
        end
        prev_pend = axi.arvalid && !axi.arready;
        prev_addr = axi.araddr;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic start_frame();
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(exp_addrs[i]);
      for (int b = 0; b < 8; b++) exp_data_q.push_back(mk_data(exp_addrs[i], b));
    end
    beats_seen = 0;
    pulse_start();
    chk1("busy_after_start", o_busy, 1'b1);
    chk1("err_cleared_on_start", o_err, 1'b0);
  endtask

  task automatic end_frame(input logic exp_err);
    int n;
    n = 0;
    while (o_finish !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("finish_seen", o_finish, 1'b1);
    chk1("busy_at_finish", o_busy, 1'b0);
    chk1("err_at_finish", o_err, exp_err);
    chk("ar_left", 128'(exp_addr_q.size()), 128'd0);
    chk("beats_left", 128'(exp_data_q.size()), 128'd0);
  endtask

  initial begin : stim
    int n;
    rst = 1'b1; i_start = 1'b0; fifo_word_counter = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_arvalid", axi.arvalid, 1'b0);
    chk1("rst_rready", axi.rready, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_finish", o_finish, 1'b0);
    chk1("rst_err", o_err, 1'b0);
    chk("rst_araddr", 128'(axi.araddr), 128'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // basic frame with a mid-frame start and a start coincident with finish
    start_frame();
    repeat (20) @(posedge clk);
    #1;
    pulse_start();
    end_frame(1'b0);
    pulse_start();
    chk1("finish_one_pulse", o_finish, 1'b0);
    chk1("start_at_finish_dropped", o_busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk1("idle_no_ar", axi.arvalid, 1'b0);

    // FIFO room gating, then AR stall and gapped R beats
    fifo_word_counter = 8'd121; ar_stall = 5; r_toggle = 1'b1;
    start_frame();
    repeat (8) @(posedge clk);
    #1;
    chk1("room_blocked", axi.arvalid, 1'b0);
    fifo_word_counter = 8'd120;
    chk1("room_edge_still_low", axi.arvalid, 1'b0);
    @(posedge clk); #1;
    chk1("room_open", axi.arvalid, 1'b1);
    end_frame(1'b0);
    fifo_word_counter = 8'd0; ar_stall = 0; r_toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // early rlast on beat 5 of the first burst
    inj_rlast_beat = 5; inj_armed = 1'b1;
    start_frame();
    end_frame(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk1("err_sticky_idle", o_err, 1'b1);

    // SLVERR on beat 3 of the first burst
    inj_rlast_beat = -1; inj_resp_beat = 3; inj_armed = 1'b1;
    start_frame();
    end_frame(1'b1);
    inj_resp_beat = -1; inj_armed = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset during beat 4 of burst 2
    start_frame();
    n = 0;
    while (beats_seen < 12 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beats_before_reset", 128'(beats_seen), 128'd12);
    rst = 1'b1;
    @(posedge clk); #1;
    chk1("mid_rst_arvalid", axi.arvalid, 1'b0);
    chk1("mid_rst_rready", axi.rready, 1'b0);
    chk1("mid_rst_dvalid", o_data_valid, 1'b0);
    chk1("mid_rst_busy", o_busy, 1'b0);
    chk1("mid_rst_finish", o_finish, 1'b0);
    chk("mid_rst_araddr", 128'(axi.araddr), 128'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("post_rst_idle", axi.arvalid, 1'b0);
    start_frame();
    end_frame(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
